fifo_ctrl: RTL and testbench
============================

FIFO_CTRL -- requirements
Module: fifo_ctrl

Interface
REQ-001 Parameter ADDR_WIDTH, default 4, memory address width.
REQ-002 Parameter BUS_SIZE, default 32, data word width (flow-through only, for valid tagging).
REQ-003 Parameter MEM_LENGTH, default 1<<ADDR_WIDTH, shall not be overridden.
REQ-004 clk  input  1  single rising-edge clock.
REQ-005 reset_L  input  1  asynchronous active-low reset.
REQ-006 push  input  1  request to write one word.
REQ-007 pop  input  1  request to read one word.
REQ-008 umbral_alto  input  ADDR_WIDTH+1  almost-full threshold, sampled in INIT.
REQ-009 umbral_bajo  input  ADDR_WIDTH+1  almost-empty threshold, sampled in INIT.
REQ-010 write  output  1  memory write enable.
REQ-011 read  output  1  memory read enable.
REQ-012 addressW  output  ADDR_WIDTH  memory write address.
REQ-013 addressR  output  ADDR_WIDTH  memory read address.
REQ-014 count  output  ADDR_WIDTH+1  stored words.
REQ-015 full, empty, almost_full, almost_empty  output  1 each  occupancy flags.
REQ-016 valid_out  output  1  memory data_out valid this cycle.
REQ-017 error  output  1  sticky overflow/underflow flag.

Function
REQ-018 FSM states: INIT, IDLE (count=0), ACTIVE (0<count<MEM_LENGTH), FULL (count=MEM_LENGTH).
REQ-019 INIT shall last exactly one cycle after reset release, latch both thresholds, ignore push/pop, then go to IDLE.
REQ-020 Accepted push = push & state!=INIT & !full; accepted pop = pop & state!=INIT & !empty.
REQ-021 write and read shall be combinational equal to accepted push/pop; addressW/addressR shall be the registered write/read pointers.
REQ-022 Each pointer shall increment by 1 per accepted operation, wrapping MEM_LENGTH-1 -> 0.
REQ-023 count shall +1 on push only, -1 on pop only, hold on both or neither.
REQ-024 Simultaneous push+pop in ACTIVE: both accepted, count unchanged, state unchanged.
REQ-025 push while full (with or without pop): push rejected, error set; pop still accepted if present.
REQ-026 pop while empty (with or without push): pop rejected, error set; push still accepted if present.
REQ-027 full = (count==MEM_LENGTH); empty = (count==0); almost_full = (count>=umbral_alto latched); almost_empty = (count<=umbral_bajo latched); all from registered count.
REQ-028 valid_out shall be registered copy of read (one-cycle memory read latency).
REQ-029 error, once set, shall stay 1 until reset.
REQ-030 Transitions: IDLE->ACTIVE on push; ACTIVE->IDLE when count goes 1->0; ACTIVE->FULL when count reaches MEM_LENGTH; FULL->ACTIVE on pop.

Reset
REQ-031 reset_L low shall immediately force: state INIT, pointers 0, count 0, empty 1, full 0, almost_full 0, almost_empty 1, valid_out 0, error 0, latched thresholds 0.
REQ-032 write and read shall be 0 while reset_L is low and during INIT.
REQ-033 Reset mid-operation shall discard all contents; no write or read shall be issued in the reset cycle.

Structure
REQ-034 ADDR_WIDTH, BUS_SIZE, MEM_LENGTH defaults and FSM state encodings shall live in shared package fifo_pkg.
REQ-035 One sub-module, ptr_wrap (enable-driven wrapping ADDR_WIDTH counter with async reset), shall be instantiated twice for write and read pointers.
REQ-036 fifo_ctrl shall connect directly to the existing memoria ports (clk, read, write, addressR, addressW) with no glue logic.

Verification
REQ-037 Reset, thresholds 12/3, 16 pushes -> addressW 0..15, count 16, full 1 after 16th edge, almost_full from count 12.
REQ-038 17th push while full -> write 0, count 16, error 1 and stays 1.
REQ-039 16 pops after fill -> read 1 each cycle, addressR 0..15, valid_out one cycle after each read, empty 1 at end.
REQ-040 count 5, push+pop together for 20 cycles -> count 5, pointers wrap past 15 to 0, error 0.
REQ-041 pop on empty with push -> write 1, read 0, count 1, error 1.
REQ-042 reset_L low at count 9 mid-stream -> all outputs to reset values immediately; one INIT cycle ignores push before IDLE.

Source files
------------

// File: rtl/fifo_pkg.sv
// Shared defaults and FSM encoding for the FIFO controller and its helpers.
package fifo_pkg;

  localparam int ADDR_WIDTH_DEF = 4;
  localparam int BUS_SIZE_DEF   = 32;

  typedef enum logic [1:0] {
    ST_INIT   = 2'd0,
    ST_IDLE   = 2'd1,
    ST_ACTIVE = 2'd2,
    ST_FULL   = 2'd3
  } fifo_state_e;

  // Memory depth always follows the address width; never set independently.
  function automatic int mem_length(input int addr_width);
    return 1 << addr_width;
  endfunction

endpackage

// File: rtl/ptr_wrap.sv
// Enable-driven address pointer that wraps naturally at 2**WIDTH.
module ptr_wrap #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en_i,
  output logic [WIDTH-1:0] ptr_o
);

  logic [WIDTH-1:0] ptr_q, ptr_d;

  always_comb ptr_d = en_i ? ptr_q + WIDTH'(1) : ptr_q;

  // NOTE: sequential state uses non-blocking assignment so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ptr_q <= '0;
    else        ptr_q <= ptr_d;
  end

  assign ptr_o = ptr_q;

endmodule

// File: rtl/fifo_ctrl.sv
// FIFO controller: pointers, occupancy count, threshold flags and sticky error
// for an external dual-port memory with one-cycle read latency.
module fifo_ctrl
  import fifo_pkg::*;
#(
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
  parameter int BUS_SIZE   = BUS_SIZE_DEF,
  parameter int MEM_LENGTH = mem_length(ADDR_WIDTH)
) (
  input  logic                  clk,
  input  logic                  reset_L,
  input  logic                  push,
  input  logic                  pop,
  input  logic [ADDR_WIDTH:0]   umbral_alto,
  input  logic [ADDR_WIDTH:0]   umbral_bajo,
  output logic                  write,
  output logic                  read,
  output logic [ADDR_WIDTH-1:0] addressW,
  output logic [ADDR_WIDTH-1:0] addressR,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  full,
  output logic                  empty,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic                  valid_out,
  output logic                  error
);

  localparam logic [ADDR_WIDTH:0] FULL_CNT = (ADDR_WIDTH+1)'(MEM_LENGTH);
  localparam logic [ADDR_WIDTH:0] CNT_ONE  = (ADDR_WIDTH+1)'(1);
  // Data words only flow through the memory; a zero-width bus never tags valid data.
  localparam logic                VALID_EN = (BUS_SIZE > 0);

  fifo_state_e         state_q, state_d;
  logic [ADDR_WIDTH:0] count_q, count_d;
  logic [ADDR_WIDTH:0] alto_q, bajo_q;
  logic                error_q, error_d;
  logic                valid_q;
  logic                active, push_ok, pop_ok;

  assign active  = (state_q != ST_INIT);
  assign full    = (count_q == FULL_CNT);
  assign empty   = (count_q == '0);
  assign push_ok = push & active & ~full;
  assign pop_ok  = pop  & active & ~empty;

  always_comb begin
    // NOTE: every comb output gets a default first so no path can infer a latch.
    state_d = state_q;
    count_d = count_q;
    error_d = error_q;
    if (push_ok && !pop_ok)      count_d = count_q + CNT_ONE;
    else if (pop_ok && !push_ok) count_d = count_q - CNT_ONE;
    if (active && ((push && full) || (pop && empty))) error_d = 1'b1;
    unique case (state_q)
      ST_INIT:   state_d = ST_IDLE;
      ST_IDLE:   if (push_ok) state_d = ST_ACTIVE;
      ST_ACTIVE: begin
        if (count_d == '0)          state_d = ST_IDLE;
        else if (count_d == FULL_CNT) state_d = ST_FULL;
      end
      ST_FULL:   if (pop_ok) state_d = ST_ACTIVE;
      default:   state_d = ST_INIT;
    endcase
  end

  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      state_q <= ST_INIT;
      count_q <= '0;
      error_q <= 1'b0;
      valid_q <= 1'b0;
      alto_q  <= '0;
      bajo_q  <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      error_q <= error_d;
      valid_q <= pop_ok & VALID_EN;
      if (state_q == ST_INIT) begin
        alto_q <= umbral_alto;
        bajo_q <= umbral_bajo;
      end
    end
  end

  ptr_wrap #(.WIDTH(ADDR_WIDTH)) u_wptr (
    .clk   (clk),
    .rst_n (reset_L),
    .en_i  (push_ok),
    .ptr_o (addressW)
  );

  ptr_wrap #(.WIDTH(ADDR_WIDTH)) u_rptr (
    .clk   (clk),
    .rst_n (reset_L),
    .en_i  (pop_ok),
    .ptr_o (addressR)
  );

  // Thresholds are meaningless until latched, so almost_full stays low through INIT.
  assign almost_full  = active & (count_q >= alto_q);
  assign almost_empty = (count_q <= bajo_q);
  assign write        = push_ok;
  assign read         = pop_ok;
  assign count        = count_q;
  assign valid_out    = valid_q;
  assign error        = error_q;

endmodule

// File: tb/tb_fifo_ctrl.sv
// Self-checking bench for fifo_ctrl: directed scenarios plus randomized traffic
// compared against a queue-based occupancy model.
module tb_fifo_ctrl;

  localparam int AW    = 4;
  localparam int DEPTH = 16;

  logic          clk = 1'b0;
  logic          reset_L = 1'b1;
  logic          push = 1'b0, pop = 1'b0;
  logic [AW:0]   umbral_alto = 5'd12, umbral_bajo = 5'd3;
  logic          write, read, full, empty, almost_full, almost_empty, valid_out, error;
  logic [AW-1:0] addressW, addressR;
  logic [AW:0]   count;

  fifo_ctrl dut (
    .clk(clk), .reset_L(reset_L), .push(push), .pop(pop),
    .umbral_alto(umbral_alto), .umbral_bajo(umbral_bajo),
    .write(write), .read(read), .addressW(addressW), .addressR(addressR),
    .count(count), .full(full), .empty(empty), .almost_full(almost_full),
    .almost_empty(almost_empty), .valid_out(valid_out), .error(error)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: queue holds the address of every stored word in order.
  int q[$];
  int wptr = 0, rptr = 0;
  int m_alto = 0, m_bajo = 0;
  bit m_init = 1'b1, m_err = 1'b0, m_valid = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_regs(input string tag);
    int n = q.size();
    check({tag, ".count"},    32'(count),        32'(n));
    check({tag, ".addressW"}, 32'(addressW),     32'(wptr));
    check({tag, ".addressR"}, 32'(addressR),     32'(rptr));
    check({tag, ".full"},     32'(full),         32'(n == DEPTH));
    check({tag, ".empty"},    32'(empty),        32'(n == 0));
    check({tag, ".afull"},    32'(almost_full),  32'(!m_init && n >= m_alto));
    check({tag, ".aempty"},   32'(almost_empty), 32'(n <= m_bajo));
    check({tag, ".valid"},    32'(valid_out),    32'(m_valid));
    check({tag, ".error"},    32'(error),        32'(m_err));
  endtask

  // One clock: drive at negedge, check combinational enables, then model the edge.
  task automatic step(input bit p, input bit o, input string tag);
    bit acc_w, acc_r;
    @(negedge clk);
    push = p;
    pop  = o;
    #1;
    acc_w = !m_init && p && (q.size() < DEPTH);
    acc_r = !m_init && o && (q.size() > 0);
    check({tag, ".write"}, 32'(write), 32'(acc_w));
    check({tag, ".read"},  32'(read),  32'(acc_r));
    if (acc_r) check({tag, ".rdaddr"}, 32'(addressR), 32'(q[0]));
    @(posedge clk);
    if (m_init) begin
      m_init  = 1'b0;
      m_alto  = int'(umbral_alto);
      m_bajo  = int'(umbral_bajo);
      m_valid = 1'b0;
    end else begin
      if ((p && q.size() == DEPTH) || (o && q.size() == 0)) m_err = 1'b1;
      if (acc_r) begin
        void'(q.pop_front());
        rptr = (rptr + 1) % DEPTH;
      end
      if (acc_w) begin
        q.push_back(wptr);
        wptr = (wptr + 1) % DEPTH;
      end
      m_valid = acc_r;
    end
    #1;
    check_regs(tag);
  endtask

  // Asynchronous reset asserted mid-cycle with requests pending; released after one edge.
  task automatic do_reset(input string tag);
    @(negedge clk);
    #2;
    push    = 1'b1;
    pop     = 1'b1;
    reset_L = 1'b0;
    #1;
    q.delete();
    wptr = 0; rptr = 0; m_alto = 0; m_bajo = 0;
    m_init = 1'b1; m_err = 1'b0; m_valid = 1'b0;
    check({tag, ".rst_write"}, 32'(write), 32'd0);
    check({tag, ".rst_read"},  32'(read),  32'd0);
    check_regs({tag, ".rst"});
    @(posedge clk);
    #2;
    reset_L = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    umbral_alto = 5'd12;
    umbral_bajo = 5'd3;
    do_reset("r0");
    step(1'b1, 1'b0, "init_push");

    for (int i = 0; i < DEPTH; i++) step(1'b1, 1'b0, "fill");
    check("fill.count16", 32'(count), 32'd16);
    check("fill.full",    32'(full),  32'd1);

    umbral_alto = 5'd2;
    step(1'b1, 1'b0, "overflow");
    step(1'b0, 1'b0, "sticky");
    check("overflow.error", 32'(error), 32'd1);

    for (int i = 0; i < DEPTH; i++) step(1'b0, 1'b1, "drain");
    step(1'b0, 1'b0, "drain_tail");
    check("drain.empty", 32'(empty), 32'd1);

    umbral_alto = 5'd12;
    do_reset("r1");
    step(1'b0, 1'b0, "init1");
    for (int i = 0; i < 5; i++)  step(1'b1, 1'b0, "pre5");
    for (int i = 0; i < 20; i++) step(1'b1, 1'b1, "pushpop");
    check("pushpop.count",    32'(count),    32'd5);
    check("pushpop.addressW", 32'(addressW), 32'd9);
    check("pushpop.error",    32'(error),    32'd0);

    for (int i = 0; i < 5; i++) step(1'b0, 1'b1, "empty5");
    step(1'b1, 1'b1, "underflow");
    check("underflow.count", 32'(count), 32'd1);
    check("underflow.error", 32'(error), 32'd1);

    umbral_alto = 5'($urandom_range(1, 16));
    umbral_bajo = 5'($urandom_range(0, 15));
    do_reset("r2");
    step(1'b0, 1'b0, "init2");
    for (int i = 0; i < 400; i++) begin
      bit fill_phase = ((i / 50) % 2) == 0;
      bit p = $urandom_range(0, 99) < (fill_phase ? 75 : 30);
      bit o = $urandom_range(0, 99) < (fill_phase ? 30 : 75);
      step(p, o, "rand");
    end

    for (int i = 0; i < DEPTH && q.size() > 0; i++) step(1'b0, 1'b1, "to_empty");
    for (int i = 0; i < 9; i++) step(1'b1, 1'b0, "to_nine");
    check("mid.count9", 32'(count), 32'd9);
    do_reset("r3");
    step(1'b1, 1'b0, "init3_push");
    step(1'b1, 1'b0, "post_init");
    check("post_init.count", 32'(count), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
